// File: rtl/pixel_reader_pkg.sv
// Shared types and constants for the on-chip pixel reader.
package pixel_reader_pkg;

    localparam int unsigned MEM_ADDR_W   = 11;
    localparam int unsigned PIX_PER_WORD = 4;
    localparam int unsigned LANE_W       = $clog2(PIX_PER_WORD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/pixel_reader_fifo.sv
// Synchronous word FIFO with occupancy count and a look-ahead of the word that
// will sit at the head after the current clock edge.
module pixel_reader_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head_next_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] remain;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push);
            rd_ptr <= rd_ptr_nxt;
            count  <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // A word pushed into an otherwise-empty FIFO becomes the head directly.
    always_comb begin
        rd_ptr_nxt  = rd_ptr + PTR_W'(pop);
        remain      = count - CNT_W'(pop);
        head_next_c = (remain == '0) ? wr_data : mem[rd_ptr_nxt];
    end

endmodule

// File: rtl/onchip_pixel_reader.sv
// Streaming reader: fetches a run of words from on-chip memory and emits them
// as little-endian 8-bit pixels. Define PIXEL_READER_ABORT_EN to add the abort input.
module onchip_pixel_reader
    import pixel_reader_pkg::*;
#(
    parameter int unsigned ADDR_W     = MEM_ADDR_W,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned PIX_W      = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     word_count,
`ifdef PIXEL_READER_ABORT_EN
    input  logic                abort,
`endif
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic [PIX_W-1:0]    pix_data,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic                pix_last
);

    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned WCNT_W = ADDR_W + 1;

    state_t               state_q, state_d;
    logic [WCNT_W-1:0]    issue_left_q, issue_left_d;
    logic [WCNT_W-1:0]    words_left_q, words_left_d;
    logic [LANE_W-1:0]    lane_q, lane_d;
    logic                 inflight_q, inflight_d;
    logic                 busy_d, done_d, cs_d, valid_d, last_d;
    logic [ADDR_W-1:0]    addr_d;
    logic [PIX_W-1:0]     pix_d;
    logic                 hs, pop, flush;
    logic [CNT_W-1:0]     fifo_count, count_nxt;
    logic [DATA_W-1:0]    head_next;
    logic [PIX_PER_WORD-1:0][PIX_W-1:0] head_lanes;

    assign mem_write      = 1'b0;
    assign mem_byteenable = '1;
    assign mem_clken      = 1'b1;

    assign hs         = pix_valid & pix_ready;
    assign pop        = hs && (lane_q == LANE_W'(PIX_PER_WORD - 1));
    assign head_lanes = head_next;

    pixel_reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .push        (inflight_q),
        .pop         (pop),
        .wr_data     (mem_readdata),
        .count       (fifo_count),
        .head_next_c (head_next)
    );

    // Next-state, issue/credit and next pixel presentation.
    always_comb begin
        state_d      = state_q;
        issue_left_d = issue_left_q;
        words_left_d = words_left_q - WCNT_W'(pop);
        lane_d       = hs ? lane_q + LANE_W'(1) : lane_q;
        addr_d       = mem_chipselect ? mem_address + ADDR_W'(1) : mem_address;
        cs_d         = 1'b0;
        inflight_d   = mem_chipselect;
        flush        = 1'b0;
        count_nxt    = fifo_count + CNT_W'(inflight_q) - CNT_W'(pop);

        case (state_q)
            IDLE: begin
                if (start) begin
                    words_left_d = word_count;
                    if (word_count != '0) begin
                        state_d      = FETCH;
                        cs_d         = 1'b1;
                        addr_d       = base_addr;
                        issue_left_d = word_count - WCNT_W'(1);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FETCH: begin
                // Credit: buffered words plus reads still in the memory pipe must fit.
                if (issue_left_q == '0) begin
                    state_d = DRAIN;
                end else if ((count_nxt + CNT_W'(mem_chipselect)) < CNT_W'(FIFO_DEPTH)) begin
                    cs_d         = 1'b1;
                    issue_left_d = issue_left_q - WCNT_W'(1);
                end
            end
            DRAIN: begin
                if (hs && pix_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef PIXEL_READER_ABORT_EN
        if (abort && ((state_q == FETCH) || (state_q == DRAIN))) begin
            state_d      = IDLE;
            cs_d         = 1'b0;
            inflight_d   = 1'b0;
            flush        = 1'b1;
            count_nxt    = '0;
            lane_d       = '0;
            issue_left_d = '0;
            words_left_d = '0;
        end
`endif

        valid_d = (count_nxt != '0);
        pix_d   = valid_d ? head_lanes[lane_d] : '0;
        last_d  = valid_d && (lane_d == LANE_W'(PIX_PER_WORD - 1)) && (words_left_d == WCNT_W'(1));
        busy_d  = (state_d == FETCH) || (state_d == DRAIN);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            issue_left_q   <= '0;
            words_left_q   <= '0;
            lane_q         <= '0;
            inflight_q     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mem_address    <= '0;
            mem_chipselect <= 1'b0;
            pix_data       <= '0;
            pix_valid      <= 1'b0;
            pix_last       <= 1'b0;
        end else begin
            state_q        <= state_d;
            issue_left_q   <= issue_left_d;
            words_left_q   <= words_left_d;
            lane_q         <= lane_d;
            inflight_q     <= inflight_d;
            busy           <= busy_d;
            done           <= done_d;
            mem_address    <= addr_d;
            mem_chipselect <= cs_d;
            pix_data       <= pix_d;
            pix_valid      <= valid_d;
            pix_last       <= last_d;
        end
    end

endmodule

// File: tb/tb_onchip_pixel_reader.sv
// Scoreboard bench for onchip_pixel_reader with a one-cycle-latency memory model.
module tb_onchip_pixel_reader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [10:0] base_addr;
    logic [11:0] word_count;
`ifdef PIXEL_READER_ABORT_EN
    logic        abort;
`endif
    logic        busy, done;
    logic [10:0] mem_address;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata;
    logic [7:0]  pix_data;
    logic        pix_valid, pix_ready, pix_last;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 0;

    logic [31:0] mem [2048];
    logic [10:0] addr_q[$];
    logic [8:0]  pix_q[$];

    int issued, popped, hs_cnt, valid_cnt, first_valid, last_hs, done_cnt, done_cyc;
    bit          stall_prev;
    logic [7:0]  stall_data;

    onchip_pixel_reader dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .word_count     (word_count),
`ifdef PIXEL_READER_ABORT_EN
        .abort          (abort),
`endif
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .pix_data       (pix_data),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_last       (pix_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_chipselect) mem_readdata <= mem[mem_address];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboards whenever the DUT presents a read or a pixel.
    always @(negedge clk) begin
        if (!reset_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 32'(pix_valid), 32'd1);
                chk("hold_data", 32'(pix_data), 32'(stall_data));
            end
            stall_prev = pix_valid && !pix_ready;
            stall_data = pix_data;
            if (mem_chipselect) begin
                issued++;
                checks++;
                if (issued - popped > 4) begin
                    errors++;
                    $display("FAIL credit: %0d words outstanding, limit 4", issued - popped);
                end
                if (addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_addr: unexpected read at 0x%0h, expected none", mem_address);
                end else begin
                    chk("rd_addr", 32'(mem_address), 32'(addr_q.pop_front()));
                end
            end
            if (pix_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (pix_valid && pix_ready) begin
                hs_cnt++;
                last_hs = cyc;
                if (pix_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pixel: unexpected pixel 0x%0h last=%0d, expected none", pix_data, pix_last);
                end else begin
                    chk("pixel{data,last}", 32'({pix_data, pix_last}), 32'(pix_q.pop_front()));
                end
                if (hs_cnt % 4 == 0) popped++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    // Consumer ready: 0 = always, 1 = one cycle in three, 2 = never.
    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pix_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (cyc % 3 == 0) : 1'b0;
        end
    end

    task automatic clear_stats();
        issued = 0; popped = 0; hs_cnt = 0; valid_cnt = 0;
        first_valid = -1; last_hs = -1; done_cnt = 0; done_cyc = -1;
    endtask

    task automatic start_run(input logic [10:0] base, input logic [11:0] wc, output int s);
        logic [10:0] a;
        logic [31:0] word;
        clear_stats();
        for (int w = 0; w < int'(wc); w++) begin
            a    = base + 11'(w);
            word = mem[a];
            addr_q.push_back(a);
            for (int l = 0; l < 4; l++)
                pix_q.push_back({word[l*8 +: 8], (w == int'(wc) - 1) && (l == 3)});
        end
        start = 1'b1; base_addr = base; word_count = wc; s = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int n;
        n = 0;
        while (done_cnt == 0 && n < max_cyc) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (done_cnt == 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles", max_cyc);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_cs"}, 32'(mem_chipselect), 32'd0);
        chk({tag, "_addr"}, 32'(mem_address), 32'd0);
        chk({tag, "_valid"}, 32'(pix_valid), 32'd0);
        chk({tag, "_data"}, 32'(pix_data), 32'd0);
        chk({tag, "_last"}, 32'(pix_last), 32'd0);
    endtask

    initial begin
        int s;
        int n;
        reset_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
`ifdef PIXEL_READER_ABORT_EN
        abort = 1'b0;
`endif
        clear_stats();
        for (int i = 0; i < 2048; i++)
            mem[i] = {i[7:0] + 8'h33, i[7:0] ^ 8'hA5, ~i[7:0], i[7:0] + 8'h01};
        mem[11'h010] = 32'h4433_2211;
        mem[11'h011] = 32'h8877_6655;

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        chk("mem_write", 32'(mem_write), 32'd0);
        chk("mem_byteenable", 32'(mem_byteenable), 32'hF);
        chk("mem_clken", 32'(mem_clken), 32'd1);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Two words, free-running consumer.
        start_run(11'h010, 12'd2, s);
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("first_cs", 32'(mem_chipselect), 32'd1);
        wait_done(50);
        chk("first_pixel_latency", 32'(first_valid - s), 32'd3);
        chk("burst_no_bubbles", 32'(last_hs - first_valid), 32'd7);
        chk("done_after_last", 32'(done_cyc - last_hs), 32'd1);
        chk("pixel_count_2w", 32'(hs_cnt), 32'd8);
        chk("done_pulse_count", 32'(done_cnt), 32'd1);

        // Zero-length run.
        start_run(11'h123, 12'd0, s);
        wait_done(20);
        chk("zero_done_cycle", 32'(done_cyc - s), 32'd1);
        chk("zero_reads", 32'(issued), 32'd0);
        chk("zero_valid", 32'(valid_cnt), 32'd0);

        // Address wrap past 0x7FF.
        start_run(11'h7FF, 12'd3, s);
        wait_done(60);
        chk("wrap_reads", 32'(issued), 32'd3);
        chk("wrap_pixels", 32'(hs_cnt), 32'd12);

        // Sixteen words under heavy backpressure.
        rdy_mode = 1;
        start_run(11'h200, 12'd16, s);
        wait_done(400);
        chk("bp_pixels", 32'(hs_cnt), 32'd64);
        chk("bp_reads", 32'(issued), 32'd16);
        chk("bp_queue_empty", 32'(pix_q.size()), 32'd0);

        // Reset in the middle of a stalled ten-word run.
        rdy_mode = 2;
        start_run(11'h100, 12'd10, s);
        repeat (8) @(posedge clk);
        #1;
        chk("midrun_busy", 32'(busy), 32'd1);
        chk("midrun_valid", 32'(pix_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        addr_q.delete();
        pix_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        start_run(11'h020, 12'd1, s);
        wait_done(30);
        chk("post_reset_pixels", 32'(hs_cnt), 32'd4);
        chk("post_reset_queue", 32'(pix_q.size()), 32'd0);

`ifdef PIXEL_READER_ABORT_EN
        // Abort while pixel 5 is presented.
        start_run(11'h040, 12'd8, s);
        n = 0;
        while (hs_cnt < 4 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("abort_reached_pixel5", 32'(hs_cnt), 32'd4);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_valid_low", 32'(pix_valid), 32'd0);
        chk("abort_busy_low", 32'(busy), 32'd0);
        addr_q.delete();
        pix_q.delete();
        repeat (6) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_stays_idle", 32'(busy), 32'd0);
        start_run(11'h050, 12'd1, s);
        wait_done(30);
        chk("post_abort_pixels", 32'(hs_cnt), 32'd4);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("addr_queue_empty", 32'(addr_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/onchip_pixel_reader.md
# onchip_pixel_reader

Streaming read engine placed directly downstream of the Nios II on-chip memory (2048 × 32-bit, single-port, one-cycle read latency). On `start` it fetches a run of words from that memory, buffers them in a small FIFO and unpacks each word into four 8-bit grayscale pixels on a valid/ready stream. The stream feeds the image coprocessor datapath. The block is the memory's second master, alongside the CPU port.

## Interface
Parameters:
- `ADDR_W`, 11: memory word-address width.
- `DATA_W`, 32: memory word width.
- `PIX_W`, 8: pixel width. `DATA_W/PIX_W` = 4 pixels per word.
- `FIFO_DEPTH`, 4: word FIFO depth. Must be a power of two and ≥ 2.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request. Sampled only in IDLE.
- `base_addr` in 11: first word address. Latched on `start`.
- `word_count` in 12: number of words to read, 0..4095. Latched on `start`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle completion pulse.
- `mem_address` out 11: read address.
- `mem_chipselect` out 1: read strobe.
- `mem_write` out 1: constant 0.
- `mem_byteenable` out 4: constant 4'hF.
- `mem_clken` out 1: constant 1.
- `mem_readdata` in 32: valid in the cycle after `mem_chipselect`.
- `pix_data` out 8: pixel.
- `pix_valid` out 1: pixel available.
- `pix_ready` in 1: consumer accepts.
- `pix_last` out 1: qualifies the final pixel of the run.

## Operation
- States:
  - IDLE → FETCH on `start` with `word_count` ≠ 0.
  - IDLE → DONE on `start` with `word_count` = 0. DONE pulses `done` and produces no pixels.
  - FETCH → DRAIN once the last read has been issued.
  - DRAIN → DONE on the final pixel handshake.
  - DONE → IDLE unconditionally.
- Issue rule: a read is issued (`mem_chipselect`=1) in FETCH only when FIFO occupancy + in-flight reads < `FIFO_DEPTH`. In-flight is 0 or 1.
- After each issue, `mem_address` increments modulo 2048. A run that passes address 2047 wraps to 0.
- `mem_readdata` is written to the FIFO unconditionally in the cycle after an issue. The credit rule guarantees space.
- Unpacking is little-endian: `[7:0]` first, then `[15:8]`, `[23:16]`, `[31:24]`.
- A 2-bit lane counter advances on each `pix_valid & pix_ready`. The FIFO pops when lane 3 is accepted.
- `pix_last` = 1 on lane 3 of the final word only.
- `pix_valid` may not drop without a handshake. `pix_data` is stable while `pix_valid` is high and `pix_ready` is low.
- `start` is ignored while `busy`.
- Reset values: `busy`, `done`, `mem_chipselect`, `pix_valid`, `pix_last` = 0. `mem_address` = 0. `pix_data` = 0. The lane counter and FIFO are empty. State is IDLE.
- Reset asserted mid-run discards all data immediately. No `done` is produced.

## Timing
- `start` is sampled at edge E0.
- First `mem_chipselect` is high in the cycle after E0, with `mem_address` = `base_addr`.
- Data is written to the FIFO at E2. `pix_valid` first rises after E2, giving a start-to-first-pixel latency of 3 cycles.
- With `pix_ready` held high, throughput is 1 pixel/cycle with no bubbles. Memory duty is 1 read per 4 cycles once the FIFO is full.
- `done` is high in the cycle after the final handshake, and `busy` falls in that same cycle.
- A new `start` is accepted in the cycle after `done`.
- Backpressure of any length loses no data. Reads stall only via the credit rule.

## Configuration
- `PIXEL_READER_ABORT_EN` defined: adds input `abort` (1 bit).
  - When `abort` is high in FETCH or DRAIN: stop issuing, flush the FIFO and the in-flight word, and drop `pix_valid` on the next cycle.
  - The block then returns to IDLE without a `done` pulse, and `busy` falls on the next cycle.
  - `abort` in IDLE or DONE has no effect.
- Not defined: the `abort` port is absent, and a run always completes.

## Structure
- Package `pixel_reader_pkg` holds:
  - the state enum (IDLE, FETCH, DRAIN, DONE);
  - `PIX_PER_WORD` = 4;
  - the lane-counter width;
  - the memory address width constant.
- Sub-module `pixel_reader_fifo`: synchronous word FIFO (`FIFO_DEPTH` × `DATA_W`) with push, pop, occupancy count and show-ahead output.
- Top level holds the FSM, address/count registers, credit logic and lane mux.

## Test plan
- `base_addr`=0x010, `word_count`=2, memory words 0x44332211 and 0x88776655, `pix_ready`=1 → pixels 11,22,33,44,55,66,77,88 on 8 consecutive cycles. First `pix_valid` is 3 cycles after `start`. `pix_last` is on 88. `done` follows 1 cycle later.
- `word_count`=0 → `done` pulses with no `mem_chipselect` and no `pix_valid`.
- `base_addr`=0x7FF, `word_count`=3 → reads issued at 0x7FF, 0x000, 0x001 in that order.
- `word_count`=16 with `pix_ready` toggling 1-of-3 cycles → all 64 pixels arrive in order. FIFO occupancy never exceeds 4, and `mem_chipselect` never fires with full credit.
- `reset_n` asserted during FETCH of a 10-word run → all outputs 0 immediately. A subsequent `start` with `word_count`=1 yields exactly 4 correct pixels.
- With `PIXEL_READER_ABORT_EN`: `abort` asserted on pixel 5 of 8 words → `pix_valid` low the next cycle, no `done`, `busy` low one cycle later. A new `start` is accepted afterwards.
